// File: rtl/verdict_pkg.sv
// verdict_pkg: shared widths, snapshot record layout and serializer states
// for the RTLola monitor verdict collector.
package verdict_pkg;
    localparam int N_STREAMS = 6;
    localparam int VAL_W = 64;
    localparam int TS_W = 32;
    localparam int ID_W = $clog2(N_STREAMS);

    typedef struct packed {
        logic [TS_W-1:0] stamp;
        logic [N_STREAMS-1:0] aktv;
        logic [N_STREAMS-1:0][VAL_W-1:0] vals;
    } snapshot_t;

    localparam int SNAP_W = $bits(snapshot_t);

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [ID_W-1:0] low_bit(input logic [N_STREAMS-1:0] m);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_STREAMS - 1; i >= 0; i--)
            if (m[i]) r = ID_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/snapshot_fifo.sv
// snapshot_fifo: first-word-fall-through snapshot buffer; exposes the head and
// the entry behind it so the serializer can chain snapshots without a bubble.
module snapshot_fifo
    import verdict_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [SNAP_W-1:0] din,
    input  logic              pop,
    output logic [SNAP_W-1:0] head,
    output logic [SNAP_W-1:0] second,
    output logic              full,
    output logic              empty,
    output logic              more
);
    localparam int AW = $clog2(DEPTH);

    logic [SNAP_W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp, count;
    logic [AW-1:0] rn;
    logic accept;

    assign count = wp - rp;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign more = count > (AW+1)'(1);
    // a pop on the same edge frees the slot, so a full FIFO still takes the push
    assign accept = push && (!full || pop);
    assign rn = rp[AW-1:0] + AW'(1);
    assign head = mem[rp[AW-1:0]];
    assign second = mem[rn];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (accept) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk)
        if (accept) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/verdict_collector.sv
// verdict_collector: timestamps active monitor output cycles, buffers them and
// serializes one valid/ready record per active stream.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_STREAMS*VAL_W-1:0] out_val,
    input  logic [N_STREAMS-1:0]       out_aktv,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [ID_W-1:0]            rec_id,
    output logic [VAL_W-1:0]           rec_value,
    output logic [TS_W-1:0]            rec_time,
    output logic                       rec_last,
    output logic                       overflow,
    output logic [15:0]                drop_count
);
    logic [TS_W-1:0] ts;
    logic push, pop, full, empty, more, fire, load;
    logic [SNAP_W-1:0] head_bits, second_bits;
    snapshot_t head, nxt, src;
    state_t state;
    logic [N_STREAMS-1:0] mask, rest, nm;
    logic [N_STREAMS-1:0][VAL_W-1:0] vals, nvals;
    logic [ID_W-1:0] nid;

    assign head = head_bits;
    assign nxt = second_bits;
    assign push = en && |out_aktv;
    assign fire = rec_valid && rec_ready;
    assign rest = mask & ~(N_STREAMS'(1) << rec_id);
    // the head stays in the FIFO until its last record is accepted
    assign pop = fire && rest == '0;
    assign src = state == IDLE ? head : nxt;
    assign load = state == IDLE ? !empty : pop && more;
    assign nm = load ? src.aktv : rest;
    assign nvals = load ? src.vals : vals;
    assign nid = low_bit(nm);

    snapshot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({ts, out_aktv, out_val}),
        .pop   (pop),
        .head  (head_bits),
        .second(second_bits),
        .full  (full),
        .empty (empty),
        .more  (more)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts <= '0;
            overflow <= 1'b0;
            drop_count <= '0;
        end else begin
            if (en) ts <= ts + TS_W'(1);
            if (push && full && !pop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mask <= '0;
            vals <= '0;
            rec_valid <= 1'b0;
            rec_id <= '0;
            rec_value <= '0;
            rec_time <= '0;
            rec_last <= 1'b0;
        end else if (load || (fire && rest != '0)) begin
            state <= EMIT;
            rec_valid <= 1'b1;
            mask <= nm;
            vals <= nvals;
            rec_id <= nid;
            rec_value <= nvals[nid];
            rec_last <= (nm & ~(N_STREAMS'(1) << nid)) == '0;
            if (load) rec_time <= src.stamp;
        end else if (fire) begin
            state <= IDLE;
            rec_valid <= 1'b0;
        end
    end
endmodule

// File: doc/verdict_collector.md
# verdict_collector

Receiving end of the monitor's output-stream interface: samples the `value`/`aktv` pairs the compiled RTLola monitor produces each cycle and timestamps every cycle with at least one active stream. Those snapshots are buffered, then serialized as one record per active stream over a valid/ready link to the host or trace sink. Sits directly downstream of the generated monitor top entity, mirroring the event feeder that drives its `input_x`/`new_input` side.

## Interface
- `N_STREAMS`, 6: number of monitor output streams (a..f).
- `VAL_W`, 64: signed width of each stream value.
- `TS_W`, 32: timestamp width.
- `DEPTH`, 8: snapshot FIFO depth, power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: capture/timestamp enable; draining is unaffected.
- `out_val`  in  N_STREAMS*VAL_W: packed stream values; stream i at bits [i*VAL_W +: VAL_W].
- `out_aktv`  in  N_STREAMS: per-stream activation flags, sampled with `out_val`.
- `rec_valid`  out  1: record available.
- `rec_ready`  in  1: sink accepts the record.
- `rec_id`  out  $clog2(N_STREAMS): stream index of the record.
- `rec_value`  out  VAL_W: stream value.
- `rec_time`  out  TS_W: timestamp of the originating snapshot.
- `rec_last`  out  1: last record of its snapshot.
- `overflow`  out  1: sticky, set when a snapshot was dropped.
- `drop_count`  out  16: saturating count of dropped snapshots.

## Operation
- Timestamp counter `ts`: resets to 0; +1 every cycle with `en`=1; wraps modulo 2^TS_W; frozen when `en`=0.
- Capture: on an edge with `en`=1 and `out_aktv`≠0, push {ts, out_aktv, out_val} into the FIFO. `out_aktv`=0 or `en`=0 pushes nothing.
- Full handling: fullness is judged on occupancy before the edge. If full and a pop happens on the same edge, the push is accepted. Otherwise the snapshot is dropped, `overflow` is set, and `drop_count` is incremented, saturating at 16'hFFFF.
- Serializer FSM:
  - IDLE: on FIFO non-empty, load the head into working registers (`mask`=aktv, values, time), register the lowest set bit as the current record, and go to EMIT.
  - EMIT: `rec_valid`=1. On `rec_valid&rec_ready`, clear that bit from `mask`.
    - If bits remain, present the next-lowest set bit on the following cycle.
    - If none remain, pop the FIFO. With another entry available, load it and stay in EMIT with no bubble; otherwise go to IDLE.
- Records within a snapshot are emitted in ascending `rec_id`. `rec_last`=1 exactly on the highest set bit.
- Reset values: `rec_valid`=0, `rec_id`=0, `rec_value`=0, `rec_time`=0, `rec_last`=0, `overflow`=0, `drop_count`=0; FIFO empty, FSM IDLE, `ts`=0.
- Reset mid-operation discards all buffered and in-flight records immediately (asynchronous). The sink must not complete a handshake during reset.

## Timing
- All `rec_*` outputs are registered and held stable while `rec_valid&!rec_ready`.
- Latency: `out_aktv`≠0 sampled at edge E0 → `rec_valid` high after edge E1 when the FIFO was empty and the FSM was IDLE.
- Throughput: one record per cycle with `rec_ready` held high, including across snapshot boundaries.
- Sustained input rate above one active stream per cycle eventually overflows. This is intended; the loss is visible only through `overflow`/`drop_count`.
- `drop_count` and `overflow` update on the same edge as the rejected push.

## Structure
- Shared package `verdict_pkg`: `N_STREAMS`, `VAL_W`, `TS_W`, `ID_W`=$clog2(N_STREAMS), the snapshot typedef {time, aktv mask, value array}, and the FSM state enum {IDLE, EMIT}.
- Sub-module `snapshot_fifo`: synchronous first-word-fall-through FIFO with parameter `DEPTH`, push/pop/full/empty, and simultaneous push+pop when full. The top level contains the timestamp counter, drop logic, and serializer FSM.

## Test plan
- Single snapshot: `en`=1, `out_aktv`=6'b000101, a=3, c=7 at ts=5, `rec_ready`=1 → records (id0, 3, t5, last0) then (id2, 7, t5, last1) on consecutive cycles, then `rec_valid`=0.
- Burst: 5 consecutive cycles, only a active, values 1..5, `rec_ready`=1 → 5 records, values 1..5, consecutive timestamps, no bubbles, each with `last`=1.
- Backpressure: `rec_ready` toggling 1,0,0,1 during a 3-record snapshot → outputs stable through the stall, no duplication or loss, order id ascending.
- Overflow: `rec_ready`=0, 10 consecutive snapshots → 8 buffered, `overflow`=1, `drop_count`=2. Then `rec_ready`=1 → exactly the first 8 snapshots drain.
- `en`=0 for 4 cycles with `out_aktv`≠0 → nothing captured and `ts` frozen; re-enable → timestamps resume with no gap.
- Reset asserted mid-drain with 3 snapshots queued → all outputs at reset values at once; after release, `ts` restarts at 0 and no stale records appear.
